// File: rtl/btn_debounce_pkg.sv
// Shared types and helpers for the multi-channel button debouncer.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_PEND   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_PEND = 2'd3
  } state_e;

  // One counter serves both debounce and hold timing, so it is sized for the largest wait.
  function automatic int cnt_width(input int dw, input int lw, input int rw);
    int m;
    m = dw;
    if (lw > m) m = lw;
    if (rw > m) m = rw;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: synchroniser, debounce FSM and counter, optional hold timer.
// Long-press/auto-repeat is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_WAIT = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int LONG_WAIT     = 64,
  parameter int REPEAT_WAIT   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level_out,
  output logic press_pls,
  output logic release_pls,
  output logic long_pls
);

  localparam int CW = cnt_width(DEBOUNCE_WAIT, LONG_WAIT, REPEAT_WAIT);
  localparam logic [CW-1:0] DW_M1 = CW'(DEBOUNCE_WAIT - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  state_e                 state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic                   level_r, press_r, release_r;
  logic                   level_s, press_s, release_s;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CW-1:0] LW_M1 = CW'(LONG_WAIT - 1);
  localparam logic [CW-1:0] RW_M1 = (REPEAT_WAIT > 0) ? CW'(REPEAT_WAIT - 1) : {CW{1'b0}};
  logic long_r, long_s;
  logic long_done_r, long_done_s;
`endif

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser shift chain for the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in};
    end
  end

  // Next-state, counter and pulse logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    press_s   = 1'b0;
    release_s = 1'b0;
`ifdef BTN_LONG_PRESS_EN
    long_s      = 1'b0;
    long_done_s = long_done_r;
`endif
    case (state_r)
      S_RELEASED: begin
        if (sync_s) begin
          if (DEBOUNCE_WAIT == 1) begin
            state_s = S_PRESSED;
            cnt_s   = '0;
            press_s = 1'b1;
          end else begin
            state_s = S_PRESS_PEND;
            cnt_s   = CW'(1);
          end
        end else begin
          cnt_s = '0;
        end
      end
      S_PRESS_PEND: begin
        if (!sync_s) begin
          state_s = S_RELEASED;
          cnt_s   = '0;
        end else if (cnt_r == DW_M1) begin
          state_s = S_PRESSED;
          cnt_s   = '0;
          press_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_PRESSED: begin
        if (!sync_s) begin
`ifdef BTN_LONG_PRESS_EN
          long_done_s = 1'b0;
`endif
          if (DEBOUNCE_WAIT == 1) begin
            state_s   = S_RELEASED;
            cnt_s     = '0;
            release_s = 1'b1;
          end else begin
            state_s = S_RELEASE_PEND;
            cnt_s   = CW'(1);
          end
        end else begin
`ifdef BTN_LONG_PRESS_EN
          // While held, cnt is the hold timer: first LONG_WAIT, then REPEAT_WAIT periods.
          if (!long_done_r) begin
            if (cnt_r == LW_M1) begin
              long_s      = 1'b1;
              long_done_s = 1'b1;
              cnt_s       = '0;
            end else begin
              cnt_s = cnt_r + CW'(1);
            end
          end else if (REPEAT_WAIT > 0) begin
            if (cnt_r == RW_M1) begin
              long_s = 1'b1;
              cnt_s  = '0;
            end else begin
              cnt_s = cnt_r + CW'(1);
            end
          end else begin
            cnt_s = cnt_r;
          end
`else
          cnt_s = '0;
`endif
        end
      end
      S_RELEASE_PEND: begin
        if (sync_s) begin
          state_s = S_PRESSED;
          cnt_s   = '0;
        end else if (cnt_r == DW_M1) begin
          state_s   = S_RELEASED;
          cnt_s     = '0;
          release_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = S_RELEASED;
        cnt_s   = '0;
      end
    endcase
    level_s = (state_s == S_PRESSED) || (state_s == S_RELEASE_PEND);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_RELEASED;
      cnt_r     <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      level_r   <= level_s;
      press_r   <= press_s;
      release_r <= release_s;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  // Long-press pulse and first-long-done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_r      <= 1'b0;
      long_done_r <= 1'b0;
    end else begin
      long_r      <= long_s;
      long_done_r <= long_done_s;
    end
  end
  assign long_pls = long_r;
`else
  assign long_pls = 1'b0;
`endif

  assign level_out   = level_r;
  assign press_pls   = press_r;
  assign release_pls = release_r;

endmodule

// File: rtl/btn_debounce_array.sv
// N_CH-channel button debouncer: polarity fix-up, per-channel debounce, any-press summary.
// Optional long-press/auto-repeat enabled by defining BTN_LONG_PRESS_EN.
module btn_debounce_array
  import btn_debounce_pkg::*;
#(
  parameter int              N_CH          = 4,
  parameter int              DEBOUNCE_WAIT = 8,
  parameter int              SYNC_STAGES   = 2,
  parameter logic [N_CH-1:0] ACTIVE_LOW    = '0,
  parameter int              LONG_WAIT     = 64,
  parameter int              REPEAT_WAIT   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pls,
  output logic [N_CH-1:0] release_pls,
  output logic            any_press,
  output logic [N_CH-1:0] long_pls
);

  logic [N_CH-1:0] btn_log_s;

  // Inversion happens ahead of the synchroniser so every channel sees 1 = pressed.
  assign btn_log_s = btn_in ^ ACTIVE_LOW;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_WAIT (DEBOUNCE_WAIT),
      .SYNC_STAGES   (SYNC_STAGES),
      .LONG_WAIT     (LONG_WAIT),
      .REPEAT_WAIT   (REPEAT_WAIT)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_in      (btn_log_s[i]),
      .level_out   (level_out[i]),
      .press_pls   (press_pls[i]),
      .release_pls (release_pls[i]),
      .long_pls    (long_pls[i])
    );
  end

  assign any_press = |press_pls;

endmodule

// File: tb/tb_btn_debounce_array.sv
// Directed self-checking bench for btn_debounce_array (channel 3 active-low).
module tb_btn_debounce_array;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_in;
  logic [3:0] level_out, press_pls, release_pls, long_pls;
  logic       any_press;

  int checks;
  int failures;
  logic [3:0] seen_press, seen_rel, seen_long;

  btn_debounce_array #(
    .N_CH          (4),
    .DEBOUNCE_WAIT (8),
    .SYNC_STAGES   (2),
    .ACTIVE_LOW    (4'b1000),
    .LONG_WAIT     (20),
    .REPEAT_WAIT   (5)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .level_out   (level_out),
    .press_pls   (press_pls),
    .release_pls (release_pls),
    .any_press   (any_press),
    .long_pls    (long_pls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each, accumulating pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      seen_press |= press_pls;
      seen_rel   |= release_pls;
      seen_long  |= long_pls;
    end
  endtask

  task automatic clear_seen();
    seen_press = 4'b0000;
    seen_rel   = 4'b0000;
    seen_long  = 4'b0000;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_seen();
    rst_n  = 1'b0;
    btn_in = 4'b1000;
    #12;
    check("rst_level", {28'd0, level_out}, 32'h0);
    check("rst_press", {28'd0, press_pls}, 32'h0);
    check("rst_any", {31'd0, any_press}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3);
    check("idle_level", {28'd0, level_out}, 32'h0);

    // Press ch0: accepted after edge 9
    btn_in = 4'b1001;
    clear_seen();
    step(9);
    check("p0_early_level", {28'd0, level_out}, 32'h0);
    check("p0_early_press", {28'd0, seen_press}, 32'h0);
    step(1);
    check("p0_level", {28'd0, level_out}, 32'h1);
    check("p0_press", {28'd0, press_pls}, 32'h1);
    check("p0_any", {31'd0, any_press}, 32'h1);
    step(1);
    check("p0_press_end", {28'd0, press_pls}, 32'h0);
    check("p0_any_end", {31'd0, any_press}, 32'h0);

    // Release ch0
    btn_in = 4'b1000;
    clear_seen();
    step(9);
    check("r0_early_level", {28'd0, level_out}, 32'h1);
    check("r0_early_rel", {28'd0, seen_rel}, 32'h0);
    step(1);
    check("r0_level", {28'd0, level_out}, 32'h0);
    check("r0_rel", {28'd0, release_pls}, 32'h1);
    step(1);
    check("r0_rel_end", {28'd0, release_pls}, 32'h0);

    // Bounce on ch1 must be rejected
    clear_seen();
    btn_in = 4'b1010; step(4);
    btn_in = 4'b1000; step(1);
    btn_in = 4'b1010; step(4);
    btn_in = 4'b1000; step(12);
    check("bnc_level", {28'd0, level_out}, 32'h0);
    check("bnc_press", {28'd0, seen_press}, 32'h0);
    btn_in = 4'b1010;
    step(9);
    check("bnc_hold_early", {28'd0, level_out}, 32'h0);
    step(1);
    check("bnc_hold_level", {28'd0, level_out}, 32'h2);
    check("bnc_hold_press", {28'd0, press_pls}, 32'h2);
    btn_in = 4'b1000;
    step(12);
    check("bnc_rel_level", {28'd0, level_out}, 32'h0);

    // Active-low ch3
    btn_in = 4'b0000;
    step(9);
    check("al3_early", {28'd0, level_out}, 32'h0);
    step(1);
    check("al3_level", {28'd0, level_out}, 32'h8);
    check("al3_press", {28'd0, press_pls}, 32'h8);

    // Simultaneous ch0 + ch2
    btn_in = 4'b0101;
    step(9);
    check("sim_early", {28'd0, level_out}, 32'h8);
    step(1);
    check("sim_level", {28'd0, level_out}, 32'hD);
    check("sim_press", {28'd0, press_pls}, 32'h5);
    check("sim_any", {31'd0, any_press}, 32'h1);
    btn_in = 4'b1000;
    step(12);
    check("sim_rel_level", {28'd0, level_out}, 32'h0);

    // Reset mid-pend on ch2 (ch0 already pressed)
    btn_in = 4'b1001;
    step(12);
    check("mr_pre_level", {28'd0, level_out}, 32'h1);
    btn_in = 4'b1101;
    step(7);
    rst_n = 1'b0;
    #2;
    check("mr_level", {28'd0, level_out}, 32'h0);
    check("mr_press", {28'd0, press_pls}, 32'h0);
    check("mr_rel", {28'd0, release_pls}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_seen();
    step(9);
    check("mr_early_level", {28'd0, level_out}, 32'h0);
    check("mr_early_press", {28'd0, seen_press}, 32'h0);
    step(1);
    check("mr_level_after", {28'd0, level_out}, 32'h5);
    check("mr_press_after", {28'd0, press_pls}, 32'h5);

    // Long press / repeat on held ch0 and ch2
    clear_seen();
`ifdef BTN_LONG_PRESS_EN
    step(19);
    check("lp_early", {28'd0, seen_long}, 32'h0);
    step(1);
    check("lp_first", {28'd0, long_pls}, 32'h5);
    step(1);
    check("lp_first_end", {28'd0, long_pls}, 32'h0);
    step(3);
    check("lp_gap", {28'd0, long_pls}, 32'h0);
    step(1);
    check("lp_repeat", {28'd0, long_pls}, 32'h5);
    btn_in = 4'b1000;
    clear_seen();
    step(30);
    check("lp_after_rel", {28'd0, seen_long}, 32'h0);
    check("lp_rel_level", {28'd0, level_out}, 32'h0);
`else
    step(40);
    check("lp_absent", {28'd0, seen_long}, 32'h0);
    check("lp_hold_level", {28'd0, level_out}, 32'h5);
    btn_in = 4'b1000;
    step(12);
    check("lp_rel_level", {28'd0, level_out}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
